// File: rtl/period_meter_if.sv
// Signal bundle between the measured source and the period meter.
// The master drives sig_in; the slave (the meter) returns the measurement.
interface period_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             sig_in;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in,
        input  half_period,
        input  period,
        input  meas_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output half_period,
        output period,
        output meas_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/period_meter.sv
// Measures edge spacing of a slow asynchronous square wave in clk cycles,
// reporting the half period, the full period, lock status and stall timeouts.
module period_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    period_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARMED, HALF, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   edge_det;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_sat;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W:0]   per_q, per_d;
    logic             mv_q, mv_d;
    logic             lk_q, lk_d;
    logic             to_q, to_d;

    assign s        = sync[SYNC_STAGES-1];
    assign edge_det = s ^ s_d;
    assign cnt_sat  = (cnt == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            s_d  <= s;
            // cnt counts cycles since the last edge, pinned at TIMEOUT
            if (edge_det)
                cnt <= CNT_W'(1);
            else if (cnt < TIMEOUT_C)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        per_d   = per_q;
        mv_d    = 1'b0;
        lk_d    = lk_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_det)
                    state_d = ARMED;
            end
            ARMED: begin
                if (edge_det) begin
                    state_d = HALF;
                    hp_d    = cnt;
                    mv_d    = 1'b1;
                end
            end
            HALF, LOCKED: begin
                if (edge_det) begin
                    state_d = LOCKED;
                    hp_d    = cnt;
                    per_d   = {1'b0, hp_q} + {1'b0, cnt};
                    mv_d    = 1'b1;
                    lk_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // an edge coinciding with saturation wins over the timeout
        if (state_q != IDLE && !edge_det && cnt_sat) begin
            state_d = IDLE;
            hp_d    = '0;
            per_d   = '0;
            lk_d    = 1'b0;
            to_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hp_q    <= '0;
            per_q   <= '0;
            mv_q    <= 1'b0;
            lk_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            per_q   <= per_d;
            mv_q    <= mv_d;
            lk_q    <= lk_d;
            to_q    <= to_d;
        end
    end

    assign bus.half_period = hp_q;
    assign bus.period      = per_q;
    assign bus.meas_valid  = mv_q;
    assign bus.locked      = lk_q;
    assign bus.timeout     = to_q;
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the toggle rate of a slow square wave, such as a divided game or tone clock or an external note signal, in clk cycles.
- Acts as the receiving end of a clock divider: a divider toggling every N+1 cycles reads back here as half_period = N+1.
- Used by game logic to check tempo and note clocks and to detect stalled signals.

Parameters:
- CNT_W, 32, width of the interval counter and of the half_period output; period output is CNT_W+1 bits.
- TIMEOUT, 100000000, maximum edge spacing in clk cycles before the measurement is dropped. Must satisfy 2 <= TIMEOUT < 2^CNT_W.
- SYNC_STAGES, 2, flop stages in the input synchronizer (>= 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  measured signal, asynchronous to clk.
- half_period  output  CNT_W  clk cycles between the last two edges of sig_in (either polarity).
- period  output  CNT_W+1  sum of the last two half_period values, i.e. one full cycle.
- meas_valid  output  1  one-cycle pulse each time half_period is updated.
- locked  output  1  high while period holds a valid full-cycle measurement.
- timeout  output  1  one-cycle pulse when TIMEOUT cycles pass without an edge.

Behaviour:
- Reset values:
  - Synchronizer flops, edge-history flop and cnt are 0.
  - half_period, period, meas_valid, locked and timeout are 0.
  - State is IDLE.
  - Reset has priority over every other event, including an edge in the same cycle.
- Input path:
  - sig_in passes through SYNC_STAGES flops to give s, then one history flop gives s_d.
  - edge = s ^ s_d.
  - Detection latency from a sampled sig_in change to the edge cycle is SYNC_STAGES+1 cycles.
  - Edge spacing is preserved exactly.
- Interval counter cnt (CNT_W bits):
  - On an edge cycle, cnt <= 1.
  - Otherwise, cnt <= cnt+1, saturating at TIMEOUT.
  - At an edge, the value of cnt before the update equals the number of clk cycles since the previous edge.
- State machine and transitions:
  - IDLE: no reference edge yet. Edge -> ARMED; nothing captured.
  - ARMED: one edge seen. Edge -> HALF with half_period <= cnt, meas_valid = 1.
  - HALF: one interval known. Edge -> LOCKED with half_period <= cnt, period <= old half_period + cnt, meas_valid = 1, locked = 1.
  - LOCKED: every edge updates half_period and period as in HALF and pulses meas_valid; stays in LOCKED.
- Timeout:
  - In ARMED, HALF or LOCKED, if cnt == TIMEOUT on a non-edge cycle, go to IDLE next cycle.
  - In that cycle: timeout = 1 for one cycle; half_period, period and locked are cleared to 0; cnt stays saturated.
  - An edge in the same cycle as cnt == TIMEOUT counts as a normal edge: the capture happens and there is no timeout.
  - In IDLE, timeout never asserts.
- Output timing: all outputs are registered. meas_valid, half_period and period update in the cycle after the edge cycle.
- Minimum spacing: edges on consecutive cycles are legal; half_period = 1.
- Reset mid-measurement: returns to IDLE and loses all history.
  - If sig_in is high at reset release, the synchronizer's 0 -> 1 transition counts as the first edge. This only arms; no capture occurs.
- period arithmetic is CNT_W+1 bits wide, so it never overflows.

Test Plan:
- Reset, then sig_in toggling every 5 cycles -> meas_valid pulses every 5 cycles starting at the 2nd edge; half_period = 5; period = 10 from the 3rd edge; locked = 1 from the 3rd edge; timeout stays 0.
- Asymmetric wave, high 3 cycles and low 7 cycles -> half_period alternates 3/7; period = 10 on every update after lock.
- TIMEOUT = 50 on the bench; lock at 5-cycle toggling, then hold sig_in steady -> timeout pulses once 50 cycles after the last edge. In the next cycle locked, half_period and period are 0. Resuming toggling rearms, and relock happens on the 3rd new edge.
- sig_in toggling every clk cycle -> half_period = 1, period = 2, meas_valid high on consecutive cycles.
- Locked at 5-cycle toggling, assert rst for 1 cycle mid-interval -> all outputs 0 the next cycle. Next capture only after 2 post-reset edges; locked again after 3.
- sig_in driven by a divider with DIV_NUM = 3 (toggle every 4 cycles) -> half_period = 4, period = 8.
